// File: rtl/aud_rmm_pkg.sv
// aud_rmm_pkg: shared encodings for the AUD remote-memory-monitor master
package aud_rmm_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_TURN, S_WAIT, S_RDATA, S_RESP
  } state_t;
  localparam logic [1:0] CMD_WR   = 2'b11;
  localparam logic [1:0] CMD_RD   = 2'b10;
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_WORD  = 2'b01;
  localparam logic [1:0] SZ_LONG  = 2'b10;
  localparam logic [1:0] SZ_ILL   = 2'b11;
  localparam logic [1:0] RSP_OK   = 2'd0;
  localparam logic [1:0] RSP_TERR = 2'd1;
  localparam logic [1:0] RSP_TMO  = 2'd2;
  localparam logic [1:0] RSP_ILL  = 2'd3;
  // index of the last data nibble for a legal size (2, 4 or 8 nibbles)
  function automatic logic [2:0] nib_last(input logic [1:0] size);
    return (size == SZ_BYTE) ? 3'd1 : (size == SZ_WORD) ? 3'd3 : (size == SZ_LONG) ? 3'd7 : 3'd0;
  endfunction
endpackage

// File: rtl/aud_nib_shift.sv
// aud_nib_shift: 32-bit nibble shift register shared by the address, write and read phases
module aud_nib_shift (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic [31:0] ld_val,
  input  logic        shf,
  input  logic        wr,
  input  logic [2:0]  idx,
  input  logic [3:0]  nib,
  output logic [31:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else if (ld) q <= ld_val;
    else if (shf) q <= {4'h0, q[31:4]};
    else if (wr) q[{idx, 2'b00} +: 4] <= nib;
  end
endmodule

// File: rtl/aud_rmm_ctrl.sv
// aud_rmm_ctrl: turns single host read/write requests into AUD nibble-protocol frames
module aud_rmm_ctrl
  import aud_rmm_pkg::*;
#(
  parameter int ADDR_NIBBLES = 8,
  parameter int TIMEOUT_CYC  = 1024,
  parameter int CNT_W        = 11
) (
  input  logic                      aud_ck,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [1:0]                req_size,
  input  logic [4*ADDR_NIBBLES-1:0] req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  output logic [1:0]                rsp_code,
  output logic [31:0]               rsp_rdata,
  output logic [3:0]                aud_data_o,
  output logic                      aud_data_oe,
  input  logic [3:0]                aud_data_i,
  output logic                      aud_nsync
);
  state_t st, nst;
  logic [2:0] cnt, cnt_n;
  logic [CNT_W-1:0] tcnt, tcnt_n;
  logic [1:0] code_q, code_n, size_q;
  logic we_q, ld, shf, wr, oe_n, nsync_n, last_addr, last_nib;
  logic [31:0] wdata_q, ld_val, q;
  logic [3:0] dout_n;
  assign last_addr = cnt == 3'(ADDR_NIBBLES - 1);
  assign last_nib = cnt == nib_last(size_q);
  aud_nib_shift u_shift (
    .clk(aud_ck), .rst(rst), .ld(ld), .ld_val(ld_val), .shf(shf), .wr(wr),
    .idx(cnt), .nib(aud_data_i), .q(q)
  );
  // pin values are computed one state ahead and registered, so every output is a flop
  always_comb begin
    nst = st;
    cnt_n = cnt;
    tcnt_n = tcnt;
    code_n = code_q;
    dout_n = aud_data_o;
    oe_n = aud_data_oe;
    nsync_n = aud_nsync;
    ld = 1'b0;
    ld_val = '0;
    shf = 1'b0;
    wr = 1'b0;
    unique case (st)
      S_IDLE: if (req_valid) begin
        ld = 1'b1;
        ld_val = 32'(req_addr);
        cnt_n = '0;
        code_n = (req_size == SZ_ILL) ? RSP_ILL : RSP_OK;
        nst = (req_size == SZ_ILL) ? S_RESP : S_CMD;
        nsync_n = req_size == SZ_ILL;
        oe_n = req_size != SZ_ILL;
        dout_n = 4'h0;
      end
      S_CMD: begin
        dout_n = {we_q ? CMD_WR : CMD_RD, size_q};
        nst = S_ADDR;
      end
      S_ADDR: begin
        dout_n = q[3:0];
        shf = 1'b1;
        cnt_n = last_addr ? 3'd0 : cnt + 3'd1;
        ld = last_addr;
        ld_val = we_q ? wdata_q : '0;
        nst = !last_addr ? S_ADDR : we_q ? S_WDATA : S_TURN;
      end
      S_WDATA: begin
        dout_n = q[3:0];
        shf = 1'b1;
        cnt_n = last_nib ? 3'd0 : cnt + 3'd1;
        nst = last_nib ? S_TURN : S_WDATA;
      end
      S_TURN: begin
        oe_n = 1'b0;
        tcnt_n = '0;
        nst = S_WAIT;
      end
      S_WAIT: begin
        // a nonzero error field outranks a simultaneous ready bit
        if (aud_data_i[3:1] != 3'b000) begin
          code_n = RSP_TERR;
          nsync_n = 1'b1;
          nst = S_RESP;
        end else if (aud_data_i[0]) begin
          code_n = RSP_OK;
          nsync_n = 1'b1;
          nst = we_q ? S_RESP : S_RDATA;
        end else begin
          tcnt_n = tcnt + CNT_W'(1);
          if (TIMEOUT_CYC != 0 && tcnt_n == CNT_W'(TIMEOUT_CYC)) begin
            code_n = RSP_TMO;
            nsync_n = 1'b1;
            nst = S_RESP;
          end
        end
      end
      S_RDATA: begin
        wr = 1'b1;
        cnt_n = cnt + 3'd1;
        nst = last_nib ? S_RESP : S_RDATA;
      end
      S_RESP: nst = S_IDLE;
    endcase
  end
  always_ff @(posedge aud_ck or posedge rst) begin
    if (rst) begin
      st <= S_IDLE;
      cnt <= '0;
      tcnt <= '0;
      code_q <= RSP_OK;
      we_q <= 1'b0;
      size_q <= SZ_BYTE;
      wdata_q <= '0;
      aud_data_o <= '0;
      aud_data_oe <= 1'b0;
      aud_nsync <= 1'b1;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_code <= RSP_OK;
      rsp_rdata <= '0;
    end else begin
      st <= nst;
      cnt <= cnt_n;
      tcnt <= tcnt_n;
      code_q <= code_n;
      aud_data_o <= dout_n;
      aud_data_oe <= oe_n;
      aud_nsync <= nsync_n;
      req_ready <= nst == S_IDLE;
      rsp_valid <= st == S_RESP;
      if (st == S_IDLE && req_valid) begin
        we_q <= req_we;
        size_q <= req_size;
        wdata_q <= req_wdata;
      end
      if (st == S_RESP) begin
        rsp_code <= code_q;
        rsp_rdata <= (code_q == RSP_OK && !we_q) ? q : '0;
      end
    end
  end
endmodule

// File: doc/aud_rmm_ctrl.md
# aud_rmm_ctrl

Parametrised second-generation AUD remote-memory-monitor (RMM) master. It converts single host read/write requests into the AUD nibble protocol: command nibble, LSB-first address nibbles, optional data, bus turnaround, and target status/data. It sits between the debug host logic and the target's AUD pins. Compared with the first-generation block it adds:
- Split pin ports instead of inout.
- A single clock edge.
- Configurable address length.
- A ready timeout and coded error responses.

## Interface
Parameters:
- ADDR_NIBBLES, 8, number of address nibbles sent (1..8); `req_addr` width is 4*ADDR_NIBBLES
- TIMEOUT_CYC, 1024, maximum WAIT cycles before timeout; 0 disables the timeout
- CNT_W, 11, width of the timeout counter; must hold TIMEOUT_CYC

Ports:
- aud_ck  in  1  AUD clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  host request valid
- req_ready  out  1  high only in IDLE
- req_we  in  1  1=write, 0=read
- req_size  in  2  00 byte, 01 word, 10 long, 11 illegal
- req_addr  in  4*ADDR_NIBBLES  target address
- req_wdata  in  32  write data, LSB-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_code  out  2  0 OK, 1 target error, 2 timeout, 3 illegal size
- rsp_rdata  out  32  read data, zero-extended; held until next rsp_valid
- aud_data_o  out  4  nibble driven to target
- aud_data_oe  out  1  pad output enable
- aud_data_i  in  4  nibble from pad
- aud_nsync  out  1  active-low frame sync

## Operation
- States: IDLE, CMD, ADDR, WDATA, TURN, WAIT, RDATA, RESP.
- Nibble count N = 2<<size: byte 2, word 4, long 8.
- IDLE, on accept (req_valid & req_ready):
  - Latch the request.
  - If size=11: go to RESP with code 3; no bus activity and nsync stays high.
  - Otherwise: nsync=0, oe=1, aud_data_o=0000, go to CMD.
- CMD: drive {2'b11,size} for write or {2'b10,size} for read; go to ADDR.
- ADDR: drive addr[4k+3:4k] for k=0..ADDR_NIBBLES-1, one per cycle. Then go to WDATA (write) or TURN (read).
- WDATA: drive wdata nibbles 0..N-1, LSB first; then go to TURN.
- TURN: oe=0 for exactly one cycle; nsync stays 0; clear the timeout counter; go to WAIT.
- WAIT: sample aud_data_i every cycle.
  - [3:1]!=0: code 1, nsync=1, go to RESP. Error wins over a simultaneous bit0.
  - Else bit0=1: ready. Write: nsync=1, go to RESP with code 0. Read: nsync=1, go to RDATA.
  - Else the counter increments. When it reaches TIMEOUT_CYC (if nonzero): code 2, nsync=1, go to RESP.
- RDATA: sample N nibbles into rdata[4k+3:4k], k=0..N-1; bits above 4N are 0. Then go to RESP with code 0.
- RESP: rsp_valid=1 for one cycle, then IDLE. rsp_rdata is updated only on a code-0 read; otherwise it is cleared to 0.
- Requests arriving outside IDLE are not accepted (req_ready=0); there is no queueing.

## Timing
- Reset values:
  - State IDLE.
  - req_ready 1, rsp_valid 0, rsp_code 0, rsp_rdata 0.
  - aud_data_o 0, aud_data_oe 0, aud_nsync 1.
  - All counters 0.
- Reset mid-transfer: pins are released immediately (oe=0, nsync=1) and no response is produced.
- All outputs are registered; the first bus nibble (0000) appears the cycle after accept.
- Write latency from accept to rsp_valid: 1+1+ADDR_NIBBLES+N+1+W+1 cycles, where W is the number of WAIT cycles including the ready cycle.
- Read latency from accept to rsp_valid: 1+1+ADDR_NIBBLES+1+W+N+1 cycles.
- The target drives its nibbles so they are stable at the rising edge of aud_ck; the block samples combinationally from aud_data_i without a synchroniser.
- Back-to-back: nsync is high for at least one cycle (RESP) between frames.

## Structure
- Package aud_rmm_pkg holds:
  - the state encoding;
  - command prefixes (CMD_WR=2'b11, CMD_RD=2'b10);
  - size codes;
  - rsp_code constants (RSP_OK, RSP_TERR, RSP_TMO, RSP_ILL).
- Sub-module aud_nib_shift provides the 32-bit nibble shift register with load, shift-out and shift-in-at-index. It is shared by the ADDR, WDATA and RDATA phases. The top level holds the FSM, nibble counter and timeout counter.

## Test plan
- Write long: addr 0x8000_1234, wdata 0xCAFE_BABE, target ready after 3 WAIT cycles.
  - Bus sequence: 0,E,4,3,2,1,0,0,0,8,E,B,A,B,E,F,A,C, then turnaround.
  - Then rsp_code 0 and latency 23.
- Read word: target ready, then nibbles 5,A,3,C → rsp_rdata 0x0000_C3A5, code 0; nsync goes high on the ready cycle.
- WAIT nibble 0011 → code 1 (error beats ready), rsp_rdata 0, no RDATA phase.
- TIMEOUT_CYC=4 with the target silent → code 2 exactly 4 WAIT cycles after TURN; oe stays 0 and nsync is 1.
- req_size=11 → rsp_valid two cycles after accept with code 3; aud_nsync never low.
- ADDR_NIBBLES=6: rst asserted mid-ADDR → oe 0 and nsync 1 immediately, no rsp_valid; a following read completes normally with 6 address nibbles.
